// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the cache-port arbiter slice.
package mem_arb_pkg;

  typedef enum logic {
    CACHE_READ  = 1'b0,
    CACHE_WRITE = 1'b1
  } cache_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester indices for issued-but-unanswered cache requests.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic                 empty,
  output logic                 full,
  output logic [clog2(DEPTH):0] count
);

  localparam int PTR_W = clog2(DEPTH);

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one cache port between NUM_REQ requesters with in-order response routing.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_valid_in,
  input  logic                      mem_ready_in,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_op,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_valid_out,
  output logic                      mem_ready_out,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      err_orphan
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_grants,
  output logic [31:0]               stat_stall
`endif
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;
  localparam logic [0:0] S_IDLE  = 1'(IDLE);
  localparam logic [0:0] S_ISSUE = 1'(ISSUE);

  logic [0:0]        state_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [ADDR_W-1:0] issue_addr_reg;
  logic [DATA_W-1:0] issue_wdata_reg;
  cache_op_e         issue_op_reg;
  logic [IDX_W-1:0]  issue_id_reg;
  logic              err_orphan_reg;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic              can_accept;
  logic              accept;
  logic              push;
  logic              pop;
  logic              rsp_live;
  logic [IDX_W-1:0]  head_idx;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign req_ready[gi] = accept && (grant_idx == IDX_W'(gi));
    assign rsp_valid[gi] = rsp_live && (head_idx == IDX_W'(gi));
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  // The issue slot counts toward the limit so a push can never find the FIFO full.
  assign can_accept = !fifo_full &&
                      ((int'(fifo_count) + ((state_reg == S_ISSUE) ? 1 : 0)) < MAX_OUTSTANDING);
  assign accept     = (state_reg == S_IDLE) && grant_found && can_accept;

  assign mem_valid_in = (state_reg == S_ISSUE);
  assign mem_addr     = issue_addr_reg;
  assign mem_op       = issue_op_reg;
  assign mem_wdata    = issue_wdata_reg;
  assign push         = mem_valid_in && mem_ready_in;

  assign rsp_live      = mem_valid_out && !fifo_empty;
  assign rsp_data      = mem_rdata;
  assign mem_ready_out = !fifo_empty && rsp_ready[head_idx];
  assign pop           = mem_valid_out && mem_ready_out;
  assign err_orphan    = err_orphan_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      rr_ptr_reg      <= '0;
      issue_addr_reg  <= '0;
      issue_wdata_reg <= '0;
      issue_op_reg    <= CACHE_READ;
      issue_id_reg    <= '0;
      err_orphan_reg  <= 1'b0;
    end else begin
      if (accept) begin
        state_reg       <= S_ISSUE;
        issue_addr_reg  <= addr_arr[grant_idx];
        issue_wdata_reg <= wdata_arr[grant_idx];
        issue_op_reg    <= cache_op_e'(req_op[grant_idx]);
        issue_id_reg    <= grant_idx;
        rr_ptr_reg      <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
      end else if (push) begin
        state_reg <= S_IDLE;
      end
      if (mem_valid_out && fifo_empty) err_orphan_reg <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .W    (IDX_W)
  ) u_id_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(issue_id_reg),
    .pop      (pop),
    .head     (head_idx),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_cnt_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [31:0] grant_cnt_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) grant_cnt_reg <= '0;
      else if (req_ready[gi] && req_valid[gi] && (grant_cnt_reg != '1))
        grant_cnt_reg <= grant_cnt_reg + 32'd1;
    end
    assign stat_grants[gi*32 +: 32] = grant_cnt_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_reg <= '0;
    else if (mem_valid_in && !mem_ready_in && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end
  assign stat_stall = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (2 requesters, 4 outstanding).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid_in, mem_ready_in, mem_op, mem_valid_out, mem_ready_out, err_orphan;
`ifdef MEM_ARB_STATS_EN
  logic [63:0] stat_grants;
  logic [31:0] stat_stall;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_w [4] = '{1, 0, 1, 0};
  int drain_h [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_valid_in(mem_valid_in), .mem_ready_in(mem_ready_in), .mem_addr(mem_addr),
    .mem_op(mem_op), .mem_wdata(mem_wdata),
    .mem_valid_out(mem_valid_out), .mem_ready_out(mem_ready_out), .mem_rdata(mem_rdata),
    .err_orphan(err_orphan)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_addr = '0; req_op = '0; req_wdata = '0;
    rsp_ready = '0; mem_ready_in = 1'b0; mem_valid_out = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_valid_in", mem_valid_in, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_ready_out", mem_ready_out, 0);
    chk("rst_err_orphan", err_orphan, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: single read from requester 0
    req_addr[31:0] = 32'h100; req_op = 2'b00; req_valid = 2'b01;
    rsp_ready = 2'b11; mem_ready_in = 1'b1;
    #1 chk("t1_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    chk("t1_mem_valid_in", mem_valid_in, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_op", mem_op, 0);
    chk("t1_req_ready_issue", req_ready, 0);
    step();
    #1 chk("t1_issue_done", mem_valid_in, 0);
    step();
    mem_valid_out = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t1_mem_ready_out", mem_ready_out, 1);
    $display("txn rsp req=0 data=0x%0h", rsp_data);
    step();
    mem_valid_out = 1'b0;
    #1 chk("t1_rsp_gone", rsp_valid, 0);

    // 2+4: both requesters continuously valid; rr_ptr is 1 after test 1
    req_addr = {32'h300, 32'h200}; req_wdata = {32'h1111_0001, 32'h0};
    req_op = 2'b10; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_grant", req_ready, 64'(1) << exp_w[i]);
      step();
      #1;
      chk("t2_mem_valid_in", mem_valid_in, 1);
      chk("t2_mem_addr", mem_addr, (exp_w[i] == 1) ? 32'h300 : 32'h200);
      chk("t2_mem_op", mem_op, exp_w[i]);
      $display("txn grant req=%0d addr=0x%0h", exp_w[i], mem_addr);
      step();
    end
    #1 chk("t4_full_gate", req_ready, 0);
    step();
    #1 chk("t4_full_gate2", req_ready, 0);
    mem_valid_out = 1'b1; mem_rdata = 32'hA1;
    #1;
    chk("t2_rsp_route1", rsp_valid, 2'b10);
    chk("t2_rsp_ready1", mem_ready_out, 1);
    step();
    mem_valid_out = 1'b0;
    #1 chk("t4_one_slot", req_ready, 2'b10);
    step();
    #1;
    chk("t4_issue_ready", req_ready, 0);
    chk("t4_issue_addr", mem_addr, 32'h300);
    step();
    #1 chk("t4_full_again", req_ready, 0);

    // 5: head (requester 0) not ready while response is presented
    mem_valid_out = 1'b1; rsp_ready = 2'b10; mem_rdata = 32'hB0;
    #1;
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_hold_ready_out", mem_ready_out, 0);
    step();
    #1;
    chk("t5_head_kept", rsp_valid, 2'b01);
    chk("t5_hold_ready_out2", mem_ready_out, 0);
    chk("t5_still_full", req_ready, 0);
    rsp_ready = 2'b11;
    #1 chk("t5_release", mem_ready_out, 1);
    step();
    req_valid = 2'b00;
    for (int j = 0; j < 3; j++) begin
      #1 chk("t5_drain_route", rsp_valid, 64'(1) << drain_h[j]);
      step();
    end
    mem_valid_out = 1'b0;
    #1 chk("t5_empty", mem_ready_out, 0);

    // 3: cache holds mem_ready_in low for 5 cycles
    req_addr[31:0] = 32'h400; req_wdata[31:0] = 32'h55; req_op = 2'b01; req_valid = 2'b01;
    #1 chk("t3_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10; mem_ready_in = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t3_valid_held", mem_valid_in, 1);
      chk("t3_addr_held", mem_addr, 32'h400);
      chk("t3_wdata_held", mem_wdata, 32'h55);
      chk("t3_op_held", mem_op, 1);
      chk("t3_no_ready", req_ready, 0);
      step();
    end
    mem_ready_in = 1'b1;
    #1 chk("t3_valid_cycle6", mem_valid_in, 1);
    step();
    #1 chk("t3_back_idle", req_ready, 2'b10);
    req_valid = 2'b00;
    mem_valid_out = 1'b1;
    #1 chk("t3_write_rsp", rsp_valid, 2'b01);
    step();
    mem_valid_out = 1'b0;

    // 6a: reset in ISSUE with 2 outstanding (grants 1,0 then 0 held; rr_ptr=1)
    req_valid = 2'b11;
    step(); step(); step(); step();
    req_valid = 2'b01;
    step();
    mem_ready_in = 1'b0; req_valid = 2'b00;
    #1 chk("t6_pre_issue", mem_valid_in, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid_in", mem_valid_in, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_op", mem_op, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    mem_valid_out = 1'b1;
    #1;
    chk("t6_rst_fifo_empty", mem_ready_out, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    mem_valid_out = 1'b0;
    step();
    reset_n = 1'b1; req_valid = 2'b11;
    #1 chk("t6_rr_reset", req_ready, 2'b01);
    req_valid = 2'b00;

    // 6b: orphan response
    mem_valid_out = 1'b1;
    #1;
    chk("t6b_rsp_valid", rsp_valid, 0);
    chk("t6b_ready_out", mem_ready_out, 0);
    chk("t6b_err_before", err_orphan, 0);
    step();
    mem_valid_out = 1'b0;
    #1 chk("t6b_err_set", err_orphan, 1);
    step(); step();
    #1 chk("t6b_err_sticky", err_orphan, 1);
    reset_n = 1'b0;
    #1 chk("t6b_err_cleared", err_orphan, 0);
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
